// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared constants for the car-request front end: debounce
//                state encoding and default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Debounce FSM state encoding (2-bit, legacy-compatible values)
    localparam logic [1:0] DB_RELEASED    = 2'd0;
    localparam logic [1:0] DB_PRESS_CHK   = 2'd1;
    localparam logic [1:0] DB_PRESSED     = 2'd2;
    localparam logic [1:0] DB_RELEASE_CHK = 2'd3;

    // 20 ms of stable level at 50 MHz
    localparam int DEBOUNCE_DEFAULT = 1000000;
    localparam int CNT_W_DEFAULT    = 20;
    localparam int WAIT_W_DEFAULT   = 3;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/car_request_sync_if.sv
`default_nettype none
// ============================================================================
//  Module      : car_request_sync_if
//  Description : Bundle of the raw key inputs, the service acknowledge from
//                intxnCtrl and the request/status outputs of car_request_sync.
//                master : the environment (keys, ew_served) side
//                slave  : the car_request_sync side
//  Revision    : 1.0 - initial release
// ============================================================================
interface car_request_sync_if #(
    parameter int WAIT_W = 3
);
    logic              key_east_n;    // raw east button, active low, async
    logic              key_west_n;    // raw west button, active low, async
    logic              ew_served;     // 1-cycle pulse on entry to EW green
    logic              car_detected;  // east_pending | west_pending
    logic              east_pending;  // latched east request
    logic              west_pending;  // latched west request
    logic [WAIT_W-1:0] east_waits;    // saturating east press count
    logic [WAIT_W-1:0] west_waits;    // saturating west press count
    logic [1:0]        press_pulse;   // {west,east} accepted-press strobes

    modport master (
        output key_east_n, key_west_n, ew_served,
        input  car_detected, east_pending, west_pending,
               east_waits, west_waits, press_pulse
    );

    modport slave (
        input  key_east_n, key_west_n, ew_served,
        output car_detected, east_pending, west_pending,
               east_waits, west_waits, press_pulse
    );
endinterface : car_request_sync_if
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchroniser, four-state debounce FSM and stability
//                counter for one active-low key. Emits a single-cycle strobe
//                when a press has been stable for DEBOUNCE_CYCLES cycles.
//  Ports       : clock, reset (async, active high)
//                key_n        - raw key, active low, asynchronous
//                press_strobe - registered 1-cycle strobe per accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  wire  clock,
    input  wire  reset,
    input  wire  key_n,
    output logic press_strobe
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_strobe;
    logic             w_pressed;

    assign w_pressed    = ~r_sync2;
    assign press_strobe = r_strobe;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Synchroniser resets to the released (high) level
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_state  <= DB_RELEASED;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_sync1  <= key_n;
            r_sync2  <= r_sync1;
            r_strobe <= 1'b0;
            case (r_state)
                DB_RELEASED: begin
                    if (w_pressed) begin
                        r_state <= DB_PRESS_CHK;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                DB_PRESS_CHK: begin
                    if (!w_pressed) begin
                        r_state <= DB_RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        // Stable long enough: accept and strobe on this edge
                        r_state  <= DB_PRESSED;
                        r_cnt    <= '0;
                        r_strobe <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DB_PRESSED: begin
                    if (!w_pressed) begin
                        r_state <= DB_RELEASE_CHK;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                DB_RELEASE_CHK: begin
                    if (w_pressed) begin
                        r_state <= DB_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        // Release accepted silently
                        r_state <= DB_RELEASED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= DB_RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule : key_debounce
`default_nettype wire

// File: rtl/car_request_sync.sv
`default_nettype none
// ============================================================================
//  Module      : car_request_sync
//  Description : Conditions the east/west car buttons into latched requests
//                for intxnCtrl. Each side is debounced, latched as pending and
//                counted (saturating) until ew_served acknowledges service.
//  Ports       : clock, reset (async, active high)
//                bus (slave) - key_east_n, key_west_n, ew_served in;
//                              car_detected, east/west_pending,
//                              east/west_waits, press_pulse out
//  Revision    : 1.0 - initial release
// ============================================================================
module car_request_sync
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int WAIT_W          = WAIT_W_DEFAULT
) (
    input wire                clock,
    input wire                reset,
    car_request_sync_if.slave bus
);

    localparam logic [WAIT_W-1:0] c_wait_max = {WAIT_W{1'b1}};

    logic [1:0]        w_key_n;
    logic [1:0]        w_strobe;
    logic [1:0]        r_pending;
    logic [WAIT_W-1:0] r_waits [2];

    // Index 0 = east, 1 = west (matches press_pulse bit order)
    assign w_key_n = {bus.key_west_n, bus.key_east_n};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_side
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_key_debounce (
                .clock        (clock),
                .reset        (reset),
                .key_n        (w_key_n[i]),
                .press_strobe (w_strobe[i])
            );

            // A press arriving with the service pulse is a new request:
            // set wins over clear and the count restarts at 1.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_pending[i] <= 1'b0;
                    r_waits[i]   <= '0;
                end else begin
                    if (w_strobe[i]) begin
                        r_pending[i] <= 1'b1;
                    end else if (bus.ew_served) begin
                        r_pending[i] <= 1'b0;
                    end

                    if (w_strobe[i] && bus.ew_served) begin
                        r_waits[i] <= WAIT_W'(1);
                    end else if (w_strobe[i]) begin
                        if (r_waits[i] != c_wait_max) begin
                            r_waits[i] <= r_waits[i] + WAIT_W'(1);
                        end
                    end else if (bus.ew_served) begin
                        r_waits[i] <= '0;
                    end
                end
            end
        end
    endgenerate

    assign bus.press_pulse  = w_strobe;
    assign bus.east_pending = r_pending[0];
    assign bus.west_pending = r_pending[1];
    assign bus.east_waits   = r_waits[0];
    assign bus.west_waits   = r_waits[1];
    assign bus.car_detected = r_pending[0] | r_pending[1];

endmodule : car_request_sync
`default_nettype wire

// File: tb/tb_car_request_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_car_request_sync
//  Description : Self-checking bench for car_request_sync with
//                DEBOUNCE_CYCLES=4: a vector table of press/serve operations
//                plus hand-written cycle-accurate sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_car_request_sync;

    localparam int DB = 4;
    localparam int WW = 3;

    typedef struct {
        int   east_low;   // cycles key_east_n held low (0 = untouched)
        int   west_low;   // cycles key_west_n held low
        bit   serve;      // issue one ew_served pulse after settling
        logic exp_ep;
        logic exp_wp;
        int   exp_ew;
        int   exp_ww;
        logic exp_cd;
        int   exp_pe;     // east strobes expected during the operation
        int   exp_pw;     // west strobes expected during the operation
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    car_request_sync_if #(.WAIT_W(WW)) bus ();

    car_request_sync #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4),
        .WAIT_W          (WW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Strobe counters sampled mid-cycle; tests read differences only
    int pe_tot = 0;
    int pw_tot = 0;
    always @(negedge clock) begin
        if (bus.press_pulse[0] === 1'b1) pe_tot <= pe_tot + 1;
        if (bus.press_pulse[1] === 1'b1) pw_tot <= pw_tot + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ep, input logic wp,
                             input int ew, input int ww, input logic cd);
        chk({tag, ".east_pending"}, 32'(bus.east_pending), 32'(ep));
        chk({tag, ".west_pending"}, 32'(bus.west_pending), 32'(wp));
        chk({tag, ".east_waits"},   32'(bus.east_waits),   32'(ew));
        chk({tag, ".west_waits"},   32'(bus.west_waits),   32'(ww));
        chk({tag, ".car_detected"}, 32'(bus.car_detected), 32'(cd));
    endtask

    task automatic apply(input string tag, input vec_t v);
        int e0, w0;
        @(negedge clock);
        e0 = pe_tot;
        w0 = pw_tot;
        for (int c = 0; c < 40; c++) begin
            bus.key_east_n = (c < v.east_low) ? 1'b0 : 1'b1;
            bus.key_west_n = (c < v.west_low) ? 1'b0 : 1'b1;
            @(negedge clock);
        end
        if (v.serve) begin
            bus.ew_served = 1'b1;
            @(negedge clock);
            bus.ew_served = 1'b0;
            @(negedge clock);
        end
        chk({tag, ".east_strobes"}, 32'(pe_tot - e0), 32'(v.exp_pe));
        chk({tag, ".west_strobes"}, 32'(pw_tot - w0), 32'(v.exp_pw));
        chk_state(tag, v.exp_ep, v.exp_wp, v.exp_ew, v.exp_ww, v.exp_cd);
    endtask

    vec_t vecs [$];

    initial begin
        int   e0, w0, ke, kw;
        bit   seen;

        bus.key_east_n = 1'b1;
        bus.key_west_n = 1'b1;
        bus.ew_served  = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clock);
        chk_state("reset", 1'b0, 1'b0, 0, 0, 1'b0);
        chk("reset.press_pulse", 32'(bus.press_pulse), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // ---------------- east press at cycle 10, held ----------------
        do begin
            @(posedge clock);
            #1;
        end while (cyc < 10);
        bus.key_east_n = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            chk($sformatf("held.pulse@%0d", cyc), 32'(bus.press_pulse[0]), 32'(cyc == 16));
            if (cyc >= 17) begin
                chk($sformatf("held.pend@%0d", cyc), 32'(bus.east_pending), 32'd1);
                chk($sformatf("held.waits@%0d", cyc), 32'(bus.east_waits), 32'd1);
                chk($sformatf("held.cd@%0d", cyc), 32'(bus.car_detected), 32'd1);
            end else begin
                chk($sformatf("held.pend@%0d", cyc), 32'(bus.east_pending), 32'd0);
            end
        end
        e0 = pe_tot;
        bus.key_east_n = 1'b1;
        repeat (12) @(negedge clock);
        chk("held.no_release_strobe", 32'(pe_tot - e0), 32'd0);

        // ---------------- table-driven operations ----------------
        //             e  w  srv ep  wp  ew ww cd  pe pw
        vecs.push_back('{8, 0, 0, 1, 0, 2, 0, 1, 1, 0});
        vecs.push_back('{8, 0, 0, 1, 0, 3, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 0, 0}); // serve with waits=3
        vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 0, 0}); // serve, nothing pending
        vecs.push_back('{0, 3, 0, 0, 0, 0, 0, 0, 0, 0}); // short west glitch
        vecs.push_back('{8, 8, 0, 1, 1, 1, 1, 1, 1, 1}); // both sides together
        vecs.push_back('{3, 8, 0, 1, 1, 1, 2, 1, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
        for (int n = 1; n <= 8; n++)                      // saturation at 7
            vecs.push_back('{8, 0, 0, 1, 0, (n > 7) ? 7 : n, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // ---------------- repeated west glitches ----------------
        @(negedge clock);
        w0 = pw_tot;
        for (int r = 0; r < 5; r++) begin
            bus.key_west_n = 1'b0;
            repeat (3) @(negedge clock);
            bus.key_west_n = 1'b1;
            repeat (3) @(negedge clock);
        end
        repeat (6) @(negedge clock);
        chk("glitch.west_strobes", 32'(pw_tot - w0), 32'd0);
        chk("glitch.west_pending", 32'(bus.west_pending), 32'd0);
        chk("glitch.car_detected", 32'(bus.car_detected), 32'd0);

        // ---------------- strobe aligned with ew_served ----------------
        apply("align.pre1", '{8, 0, 0, 1, 0, 1, 0, 1, 1, 0});
        apply("align.pre2", '{8, 0, 0, 1, 0, 2, 0, 1, 1, 0});
        bus.key_east_n = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (bus.press_pulse[0] === 1'b1) seen = 1'b1;
        end
        chk("align.strobe_seen", 32'(seen), 32'd1);
        bus.ew_served = 1'b1;
        @(negedge clock);
        bus.ew_served = 1'b0;
        chk_state("align", 1'b1, 1'b0, 1, 0, 1'b1);
        bus.key_east_n = 1'b1;
        repeat (12) @(negedge clock);

        // ---------------- reset during PRESS_CHK ----------------
        bus.key_east_n = 1'b0;
        bus.key_west_n = 1'b0;
        repeat (3) @(negedge clock);   // sync, sync, enter PRESS_CHK
        reset = 1'b1;
        #1;
        chk_state("rst_mid.a", 1'b0, 1'b0, 0, 0, 1'b0);
        chk("rst_mid.a.pulse", 32'(bus.press_pulse), 32'd0);
        @(negedge clock);
        chk_state("rst_mid.b", 1'b0, 1'b0, 0, 0, 1'b0);
        chk("rst_mid.b.pulse", 32'(bus.press_pulse), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        e0 = pe_tot;
        w0 = pw_tot;
        ke = 0;
        kw = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock);
            #1;
            if (bus.press_pulse[0] === 1'b1 && ke == 0) ke = k;
            if (bus.press_pulse[1] === 1'b1 && kw == 0) kw = k;
        end
        chk("rst_mid.east_strobe_edge", 32'(ke), 32'd6);
        chk("rst_mid.west_strobe_edge", 32'(kw), 32'd6);
        repeat (6) @(negedge clock);
        chk("rst_mid.east_strobes", 32'(pe_tot - e0), 32'd1);
        chk("rst_mid.west_strobes", 32'(pw_tot - w0), 32'd1);
        chk_state("rst_mid.after", 1'b1, 1'b1, 1, 1, 1'b1);
        bus.key_east_n = 1'b1;
        bus.key_west_n = 1'b1;
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_car_request_sync
`default_nettype wire
